// File: rtl/btn_chord_debouncer.sv
// btn_chord_debouncer
// Conditions the four raw keypad buttons for the door-lock sequence checker.
// It synchronises each button and debounces all four together as one chord.
// The held chord is presented on btn_clean, with one-cycle press and release strobes.
// btn_clean only changes after the synchronised chord has been constant for
// DEBOUNCE_CYCLES+1 consecutive evaluations. Bounces, glitches and skewed partial
// chords therefore never reach the lock FSM.
// Optional feature: define BTN_PRESS_CNT_EN to add a saturating 8-bit press counter.

module btn_chord_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_clean,
   output logic       btn_valid,
   output logic       btn_release
`ifdef BTN_PRESS_CNT_EN
   ,
   output logic [7:0] press_count
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       sync_chain [SYNC_STAGES];
   logic [3:0]       sync;
   logic [3:0]       cand;
   logic [3:0]       cand_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [3:0]       clean_next;
   logic             valid_next;
   logic             release_next;

   assign sync = sync_chain[SYNC_STAGES-1];

   // Per-bit synchroniser chain that brings the asynchronous buttons into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= 4'b0000;
         end
      end else begin
         sync_chain[0] <= btn_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= sync_chain[i-1];
         end
      end
   end

   // State register together with the candidate chord, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= STABLE;
         cand        <= 4'b0000;
         cnt         <= '0;
         btn_clean   <= 4'b0000;
         btn_valid   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         state       <= state_next;
         cand        <= cand_next;
         cnt         <= cnt_next;
         btn_clean   <= clean_next;
         btn_valid   <= valid_next;
         btn_release <= release_next;
      end
   end

   // Next-state logic: leave STABLE on any change, return once the chord is accepted or bounces back
   always_comb begin
      state_next = state;
      case (state)
         STABLE: begin
            if (sync != cand) begin
               state_next = SETTLING;
            end
         end
         SETTLING: begin
            if (sync != cand) begin
               if (sync == btn_clean) begin
                  state_next = STABLE;
               end
            end else if (cnt == CNT_MAX) begin
               state_next = STABLE;
            end
         end
         default: state_next = STABLE;
      endcase
   end

   // Datapath and strobe values: restart on any bit change, count while steady, accept at the limit
   always_comb begin
      cand_next    = cand;
      cnt_next     = cnt;
      clean_next   = btn_clean;
      valid_next   = 1'b0;
      release_next = 1'b0;
      case (state)
         STABLE: begin
            if (sync != cand) begin
               cand_next = sync;
               cnt_next  = '0;
            end
         end
         SETTLING: begin
            if (sync != cand) begin
               cand_next = sync;
               cnt_next  = '0;
            end else if (cnt < CNT_MAX) begin
               cnt_next = cnt + CNT_W'(1);
            end else begin
               clean_next   = cand;
               valid_next   = (cand != 4'b0000);
               release_next = (cand == 4'b0000);
            end
         end
         default: begin
            cand_next = cand;
         end
      endcase
   end

`ifdef BTN_PRESS_CNT_EN
   // Count accepted presses, updating in the same cycle as btn_valid and sticking at 255
   always_ff @(posedge clk) begin
      if (reset) begin
         press_count <= 8'd0;
      end else if (valid_next && (press_count != 8'hFF)) begin
         press_count <= press_count + 8'd1;
      end
   end
`endif

endmodule
